// File: rtl/bist_mem_target.sv
// Memory-under-test responder for the BIST controller: a 16x8 register file behind a
// valid/ready port with programmable latency and selectable injected faults.
module bist_mem_target #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    input  logic [1:0]    cfg_lat,
    input  logic          flt_en,
    input  logic [1:0]    flt_mode,
    input  logic [AW-1:0] flt_addr,
    input  logic [2:0]    flt_bit,
    output logic [7:0]    acc_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [1:0]    lat_cnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          flt_en_q;
    logic [1:0]    flt_mode_q;
    logic [AW-1:0] flt_addr_q;
    logic [2:0]    flt_bit_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          rsp_we_q;
    logic [DW-1:0] rsp_rdata_q;
    logic [7:0]    acc_cnt_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_flt_en;
    logic [1:0]    cmd_flt_mode;
    logic [AW-1:0] cmd_flt_addr;
    logic [2:0]    cmd_flt_bit;
    logic          flt_hit;
    logic [AW-1:0] eff_addr;
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] wword_d;
    logic          accept;
    logic          do_access;

    // A zero-latency command is accessed on its accept edge, so the live inputs
    // stand in for the not-yet-latched copies while in IDLE.
    always_comb begin
        cmd_we       = we_q;
        cmd_addr     = addr_q;
        cmd_wdata    = wdata_q;
        cmd_flt_en   = flt_en_q;
        cmd_flt_mode = flt_mode_q;
        cmd_flt_addr = flt_addr_q;
        cmd_flt_bit  = flt_bit_q;
        if (state_q == IDLE) begin
            cmd_we       = req_we;
            cmd_addr     = req_addr;
            cmd_wdata    = req_wdata;
            cmd_flt_en   = flt_en;
            cmd_flt_mode = flt_mode;
            cmd_flt_addr = flt_addr;
            cmd_flt_bit  = flt_bit;
        end

        flt_hit  = cmd_flt_en && (cmd_addr == cmd_flt_addr);
        eff_addr = cmd_addr;
        if (flt_hit && cmd_flt_mode == 2'd2) begin
            eff_addr = cmd_addr ^ AW'(1);
        end

        rdata_d = mem_q[eff_addr];
        if (flt_hit && cmd_flt_mode == 2'd0) begin
            rdata_d[cmd_flt_bit] = 1'b0;
        end
        if (flt_hit && cmd_flt_mode == 2'd1) begin
            rdata_d[cmd_flt_bit] = 1'b1;
        end

        // Slow-rise cell: the faulty bit can only hold or fall on a write.
        wword_d = cmd_wdata;
        if (flt_hit && cmd_flt_mode == 2'd3) begin
            wword_d[cmd_flt_bit] = mem_q[eff_addr][cmd_flt_bit] & cmd_wdata[cmd_flt_bit];
        end

        accept    = (state_q == IDLE) && req_valid && req_ready_q;
        do_access = (accept && cfg_lat == 2'd0) ||
                    (state_q == WAIT && lat_cnt_q == 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_access && cmd_we) begin
            mem_q[eff_addr] <= wword_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 2'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            flt_en_q    <= 1'b0;
            flt_mode_q  <= 2'd0;
            flt_addr_q  <= '0;
            flt_bit_q   <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            acc_cnt_q   <= 8'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        flt_en_q    <= flt_en;
                        flt_mode_q  <= flt_mode;
                        flt_addr_q  <= flt_addr;
                        flt_bit_q   <= flt_bit;
                        lat_cnt_q   <= cfg_lat;
                        state_q     <= (cfg_lat == 2'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt_q <= lat_cnt_q - 2'd1;
                    if (lat_cnt_q == 2'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    acc_cnt_q   <= acc_cnt_q + 8'd1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (do_access) begin
                rsp_we_q    <= cmd_we;
                rsp_rdata_q <= cmd_we ? '0 : rdata_d;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign acc_cnt   = acc_cnt_q;

endmodule
